// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: shared widths and encodings for the vector execute stage
package vector_alu_pkg;
  localparam int LANE_W = 8;
  localparam int LANES = 24;
  localparam int VEC_W = 192;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_MUL, ALU_PASSB} alu_op_e;
  typedef enum logic [1:0] {SRC2_REG, SRC2_NUM, SRC2_ONE, SRC2_ZERO} src2_e;
  typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: combinational single-lane add/sub/mul/pass-b
module vector_lane_alu
  import vector_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] y
);
  always_comb y = op == ALU_ADD ? a + b : op == ALU_SUB ? a - b : op == ALU_MUL ? a * b : b;
endmodule

// File: rtl/vector_alu_ex.sv
// vector_alu_ex: multi-cycle lane-chunked scalar/vector execute stage
module vector_alu_ex
  import vector_alu_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int LANES = 24,
  parameter int LANES_PER_CYCLE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic                      flush,
  input  logic [1:0]                alu_op,
  input  logic                      vector_op,
  input  logic                      alu_src1,
  input  logic [1:0]                alu_src2,
  input  logic [LANE_W*LANES-1:0]   pc,
  input  logic [LANE_W*LANES-1:0]   rss1,
  input  logic [LANE_W*LANES-1:0]   rss2,
  input  logic [LANE_W*LANES-1:0]   rvs1,
  input  logic [LANE_W*LANES-1:0]   rvs2,
  input  logic [LANE_W*LANES-1:0]   num,
  input  logic [3:0]                rr_in,
  output logic                      stall,
  output logic                      busy,
  output logic [LANE_W*LANES-1:0]   result,
  output logic [3:0]                rr_out,
  output logic                      result_valid
);
  localparam int W = LANE_W * LANES;
  localparam int NUM_CHUNKS = LANES / LANES_PER_CYCLE;
  localparam int CW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  state_e state;
  logic [CW-1:0] cnt;
  logic [W-1:0] a_q, b_q, acc, acc_nxt, a_sel, b_sel, ones;
  alu_op_e op_q;
  logic vec_q, last, accept;
  logic [3:0] rr_q;
  logic [LANES_PER_CYCLE-1:0][LANE_W-1:0] ca, cb, cy;
  assign ones = {LANES{LANE_W'(1)}};
  assign a_sel = alu_src1 ? pc : vector_op ? rvs1 : rss1;
  assign b_sel = alu_src2 == SRC2_REG ? (vector_op ? rvs2 : rss2) :
                 alu_src2 == SRC2_NUM ? num : alu_src2 == SRC2_ONE ? ones : '0;
  assign last = state == BUSY && (!vec_q || cnt == CW'(NUM_CHUNKS - 1));
  assign stall = state == BUSY && !last;
  assign busy = state == BUSY;
  assign accept = (state == IDLE || last) && valid_in && !flush;
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < LANES_PER_CYCLE; i++) begin
      ca[i] = a_q[(int'(cnt) * LANES_PER_CYCLE + i) * LANE_W +: LANE_W];
      cb[i] = b_q[(int'(cnt) * LANES_PER_CYCLE + i) * LANE_W +: LANE_W];
    end
  end
  for (genvar i = 0; i < LANES_PER_CYCLE; i++) begin : g_lane
    vector_lane_alu #(.W(LANE_W)) u_lane (.a(ca[i]), .b(cb[i]), .op(op_q), .y(cy[i]));
  end
  always_comb begin
    acc_nxt = vec_q ? acc : '0;
    for (int i = 0; i < LANES_PER_CYCLE; i++)
      if (vec_q || i == 0) acc_nxt[(int'(cnt) * LANES_PER_CYCLE + i) * LANE_W +: LANE_W] = cy[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      op_q <= ALU_ADD;
      vec_q <= 1'b0;
      rr_q <= '0;
      result <= '0;
      rr_out <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        if (state == BUSY) acc <= acc_nxt;
        if (last) begin
          result <= acc_nxt;
          rr_out <= rr_q;
          result_valid <= 1'b1;
          state <= IDLE;
        end else if (state == BUSY) begin
          cnt <= cnt + CW'(1);
        end
        if (accept) begin
          a_q <= a_sel;
          b_q <= b_sel;
          op_q <= alu_op_e'(alu_op);
          vec_q <= vector_op;
          rr_q <= rr_in;
          cnt <= '0;
          state <= BUSY;
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_alu_ex.sv
// tb_vector_alu_ex: scoreboard bench for the vector execute stage
module tb_vector_alu_ex;
  logic clk = 0, rst = 1, valid_in = 0, flush = 0, vector_op = 0, alu_src1 = 0;
  logic [1:0] alu_op = 0, alu_src2 = 0;
  logic [191:0] pc = '0, rss1 = '0, rss2 = '0, rvs1 = '0, rvs2 = '0, num = '0;
  logic [3:0] rr_in = 0;
  logic stall, busy, result_valid;
  logic [191:0] result;
  logic [3:0] rr_out;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, n_valid = 0, valid_cyc = 0, prev_valid_cyc = 0, stall_hi = 0;
  int n0, s0;
  logic [195:0] sb[$];
  logic [195:0] last_exp = '0, mon_e, prior;
  vector_alu_ex dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .alu_op(alu_op),
    .vector_op(vector_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .pc(pc),
    .rss1(rss1), .rss2(rss2), .rvs1(rvs1), .rvs2(rvs2), .num(num), .rr_in(rr_in),
    .stall(stall), .busy(busy), .result(result), .rr_out(rr_out), .result_valid(result_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (stall) stall_hi++;
  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [191:0] model(input logic [1:0] op, input logic vec,
                                         input logic [191:0] a, input logic [191:0] b);
    logic [191:0] r = '0;
    int x, y, z;
    for (int l = 0; l < 24; l++)
      if (vec || l == 0) begin
        x = int'(a[l*8 +: 8]);
        y = int'(b[l*8 +: 8]);
        z = op == 0 ? x + y : op == 1 ? x - y + 256 : op == 2 ? x * y : y;
        r[l*8 +: 8] = 8'(z % 256);
      end
    return r;
  endfunction
  always @(posedge clk) begin
    #1;
    if (result_valid) begin
      n_valid++;
      prev_valid_cyc = valid_cyc;
      valid_cyc = cyc;
      if (sb.size() == 0) chk("unexpected_valid", 192'(1), 192'(0));
      else begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e[191:0]);
        chk("rr_out", 192'(rr_out), 192'(mon_e[195:192]));
      end
    end
  end
  task automatic issue(input logic [1:0] op, input logic vec, input logic s1,
                       input logic [1:0] s2, input logic [3:0] rr, input bit push);
    logic [191:0] a, b;
    int n = 0;
    @(negedge clk);
    alu_op = op; vector_op = vec; alu_src1 = s1; alu_src2 = s2; rr_in = rr; valid_in = 1;
    while (stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (stall) chk("accept_timeout", 192'(stall), 192'(0));
    a = s1 ? pc : vec ? rvs1 : rss1;
    b = s2 == 0 ? (vec ? rvs2 : rss2) : s2 == 1 ? num : s2 == 2 ? {24{8'h01}} : '0;
    if (push) begin
      last_exp = {rr, model(op, vec, a, b)};
      sb.push_back(last_exp);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask
  task automatic idle();
    @(negedge clk);
    valid_in = 0;
  endtask
  task automatic wait_valid(input int target);
    int n = 0;
    while (n_valid < target && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("valid_timeout", 192'(n_valid >= target), 192'(1));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_rr", 192'(rr_out), 192'(0));
    chk("rst_valid", 192'(result_valid), 192'(0));
    chk("rst_stall", 192'(stall), 192'(0));
    chk("rst_busy", 192'(busy), 192'(0));
    rst = 0;
    rss1 = 192'h05; rss2 = 192'h03;
    n0 = n_valid; s0 = stall_hi;
    issue(0, 0, 0, 0, 3, 1);
    idle();
    wait_valid(n0 + 1);
    chk("add_lat", 192'(valid_cyc - acc_cyc), 192'(1));
    chk("add_val", result, 192'h08);
    repeat (3) @(negedge clk);
    chk("add_pulse", 192'(n_valid), 192'(n0 + 1));
    chk("add_nostall", 192'(stall_hi - s0), 192'(0));
    rvs1 = '0; num = {24{8'h01}};
    n0 = n_valid; s0 = stall_hi;
    issue(1, 1, 0, 1, 4, 1);
    idle();
    wait_valid(n0 + 1);
    chk("sub_lat", 192'(valid_cyc - acc_cyc), 192'(3));
    chk("sub_stall", 192'(stall_hi - s0), 192'(2));
    chk("sub_val", result, {24{8'hFF}});
    for (int i = 0; i < 24; i++) rvs1[i*8 +: 8] = 8'(i);
    rvs2 = {24{8'h10}};
    n0 = n_valid;
    issue(2, 1, 0, 0, 7, 1);
    idle();
    wait_valid(n0 + 1);
    chk("mul_l16", 192'(result[16*8 +: 8]), 192'(8'h00));
    chk("mul_l17", 192'(result[17*8 +: 8]), 192'(8'h10));
    chk("mul_l23", 192'(result[23*8 +: 8]), 192'(8'h70));
    for (int i = 0; i < 6; i++) begin
      rvs1[i*32 +: 32] = $urandom;
      rvs2[i*32 +: 32] = $urandom;
    end
    num = 192'hAA;
    n0 = n_valid;
    issue(0, 1, 0, 0, 5, 1);
    issue(3, 0, 0, 1, 6, 1);
    idle();
    wait_valid(n0 + 2);
    chk("b2b_gap", 192'(valid_cyc - prev_valid_cyc), 192'(1));
    chk("b2b_lat", 192'(valid_cyc - acc_cyc), 192'(1));
    chk("b2b_val", 192'(result[7:0]), 192'(8'hAA));
    prior = last_exp;
    n0 = n_valid;
    issue(0, 1, 0, 0, 9, 0);
    idle();
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_stall", 192'(stall), 192'(0));
    chk("flush_busy", 192'(busy), 192'(0));
    chk("flush_result", result, prior[191:0]);
    chk("flush_rr", 192'(rr_out), 192'(prior[195:192]));
    repeat (4) @(negedge clk);
    chk("flush_novalid", 192'(n_valid), 192'(n0));
    rss1 = 192'h10; rss2 = 192'h20;
    issue(0, 0, 0, 0, 2, 1);
    idle();
    wait_valid(n0 + 1);
    chk("post_flush_lat", 192'(valid_cyc - acc_cyc), 192'(1));
    n0 = n_valid;
    issue(0, 1, 0, 0, 11, 0);
    idle();
    @(negedge clk);
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstmid_result", result, '0);
    chk("rstmid_rr", 192'(rr_out), 192'(0));
    chk("rstmid_valid", 192'(result_valid), 192'(0));
    chk("rstmid_stall", 192'(stall), 192'(0));
    chk("rstmid_busy", 192'(busy), 192'(0));
    chk("rstmid_novalid", 192'(n_valid), 192'(n0));
    rst = 0;
    rss1 = 192'h01; rss2 = 192'h02; pc = 192'h40;
    issue(0, 0, 1, 2, 12, 1);
    idle();
    wait_valid(n0 + 1);
    chk("post_rst_lat", 192'(valid_cyc - acc_cyc), 192'(1));
    chk("post_rst_val", result, 192'h41);
    repeat (3) @(negedge clk);
    chk("sb_empty", 192'(sb.size()), 192'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
